circuit_equiv_sequencer: RTL and testbench
==========================================

# circuit_equiv_sequencer

Self-checking stimulus sequencer for the three-input circuit experiments. It drives one shared 3-bit input vector (a, b, c) into the switch-level, assign-level and gate-level implementations of the same circuit. After a programmable settle time it samples all three 2-bit result pairs and reports whether the implementations agree on every vector. It replaces hand-timed `#100` stimulus with a clocked, repeatable sweep usable in simulation and on the board.

## Interface
Parameters:
- SETTLE_CYCLES, 4, cycles the vector is held before sampling; legal range 1..255.
- SEQ_MODE, 0, vector order: 0 = binary sweep 000..111 (8 vectors); 1 = Johnson walk 000,100,110,111,011,001 (6 vectors, a is bit 2).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a sweep when idle, ignored while busy.
- abort  in  1  synchronous; returns to IDLE next edge, no done pulse.
- a, b, c  out  1 each  shared stimulus to all three implementations.
- y_sw  in  2  {y1, y0} from the switch-level implementation.
- y_as  in  2  {y1, y0} from the assign-level implementation.
- y_gt  in  2  {y1, y0} from the gate-level implementation.
- busy  out  1  high from the cycle after start until DONE.
- done  out  1  one-cycle pulse at sweep end.
- pass  out  1  valid with done and held until next start; 1 = no mismatch.
- err_count  out  4  number of mismatching vectors in the current or last sweep.
- fail_valid  out  1  set on first mismatch of a sweep.
- fail_vec  out  3  {a,b,c} of first mismatch.
- fail_y  out  6  {y_sw, y_as, y_gt} captured at first mismatch.

## Operation
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE: a,b,c = 000. On start, go to DRIVE. Clear err_count, fail_valid, fail_vec, fail_y and pass. Load vector index 0.
- DRIVE: register the vector for the current index onto a,b,c. Load the settle counter with SETTLE_CYCLES-1, then go to SETTLE.
- SETTLE: decrement the counter; at 0 go to SAMPLE.
- SAMPLE:
  - Mismatch = (y_sw != y_as) or (y_as != y_gt).
  - On mismatch, increment err_count (saturating at 15).
  - On the first mismatch only, also set fail_valid and capture fail_vec and fail_y.
  - Then go to DRIVE if the index is not last (index+1), else go to DONE.
- DONE: pulse done for one cycle. pass = (err_count == 0 including this sample). Return to IDLE; a,b,c return to 000.
- Vector table is a constant lookup selected by SEQ_MODE. The index counter is 3 bits and wraps only via the DONE transition.
- abort in any state: go to IDLE. Force a,b,c = 000 and keep err_count/fail_* as accumulated. pass = 0, busy = 0, no done.
- start and abort asserted together: abort wins.
- Reset, asynchronous at any time: state IDLE, a=b=c=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_vec=0, fail_y=0.

## Timing
- start sampled at edge N → DRIVE at N+1, vector visible and busy=1 after edge N+1.
- Each vector occupies exactly 1 (DRIVE) + SETTLE_CYCLES (SETTLE) + 1 (SAMPLE) cycles. Sampling uses y_* at the SAMPLE edge, i.e. SETTLE_CYCLES+1 edges after the vector changed.
- Sweep length (start to done) = 1 + V·(SETTLE_CYCLES+2) cycles, where V = 8 or 6.
- done is high for exactly one cycle; busy falls in the same cycle done rises.
- pass, err_count and fail_* change only in SAMPLE/DONE or on start/reset.

## Structure
- Shared package `circuit_seq_pkg`:
  - state encoding enum;
  - the two vector-table constants;
  - VEC_W = 3 and Y_W = 2.
- One sub-module, `equiv_compare`: purely combinational 3-way 2-bit comparator producing mismatch. Everything else lives in the top FSM.

## Test plan
- Identical DUT copies (all y_* tied to the same function, e.g. y1=a&b, y0=b|c), SEQ_MODE=0, SETTLE=4 → done 49 cycles after start, pass=1, err_count=0, a,b,c stepping 000..111.
- SEQ_MODE=1 with identical copies → vectors 000,100,110,111,011,001 in order, done after 37 cycles, pass=1.
- Force y_gt bit0 inverted when vector=101 → err_count=1, fail_vec=101, fail_valid=1, pass=0.
- Force y_sw wrong on 011 and 110 → err_count=2, fail_vec=011 (first in binary order), fail_y captured at 011 only.
- abort during SETTLE of vector 3 → busy=0 next cycle, a,b,c=000, no done pulse. A new start then runs a full clean sweep with pass=1.
- rst_n low mid-sweep for 1 ns between edges → all outputs to reset values immediately. Remain IDLE until start; start during busy is ignored.

Source files
------------

// File: rtl/circuit_seq_pkg.sv
// Shared types and constants for the circuit equivalence sequencer.
package circuit_seq_pkg;

   localparam int VEC_W = 3;
   localparam int Y_W   = 2;
   localparam int ERR_W = 4;

   typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE} seqState_e;

   // Johnson table is padded to eight entries so both tables share the same 3-bit index.
   localparam logic [7:0][VEC_W-1:0] BINARY_VECS =
      {3'b111, 3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b001, 3'b000};
   localparam logic [7:0][VEC_W-1:0] JOHNSON_VECS =
      {3'b000, 3'b000, 3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000};

   function automatic logic [VEC_W-1:0] vecAt(input logic johnson, input logic [2:0] idx);
      return johnson ? JOHNSON_VECS[idx] : BINARY_VECS[idx];
   endfunction

   function automatic logic [2:0] lastIndex(input logic johnson);
      return johnson ? 3'd5 : 3'd7;
   endfunction

endpackage

// File: rtl/circuit_equiv_sequencer_if.sv
// Stimulus/result bundle between the sequencer (slave) and the harness around the three implementations (master).
interface circuit_equiv_sequencer_if;
   import circuit_seq_pkg::*;

   logic             start;
   logic             abort;
   logic             a;
   logic             b;
   logic             c;
   logic [Y_W-1:0]   y_sw;
   logic [Y_W-1:0]   y_as;
   logic [Y_W-1:0]   y_gt;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_count;
   logic             fail_valid;
   logic [VEC_W-1:0] fail_vec;
   logic [3*Y_W-1:0] fail_y;

   modport master (
      output start, abort, y_sw, y_as, y_gt,
      input  a, b, c, busy, done, pass, err_count, fail_valid, fail_vec, fail_y
   );

   modport slave (
      input  start, abort, y_sw, y_as, y_gt,
      output a, b, c, busy, done, pass, err_count, fail_valid, fail_vec, fail_y
   );

endinterface

// File: rtl/equiv_compare.sv
// Three-way comparator: flags any disagreement between the switch, assign and gate level results.
module equiv_compare
   import circuit_seq_pkg::*;
(
   input  logic [Y_W-1:0] ySw_i,
   input  logic [Y_W-1:0] yAs_i,
   input  logic [Y_W-1:0] yGt_i,
   output logic           mismatch_o
);

   assign mismatch_o = (ySw_i != yAs_i) || (yAs_i != yGt_i);

endmodule

// File: rtl/circuit_equiv_sequencer.sv
// Sweeps a shared (a,b,c) vector through three implementations of one circuit and
// reports whether their results agree on every vector after a settle time.
module circuit_equiv_sequencer
   import circuit_seq_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4,
   parameter int SEQ_MODE      = 0
) (
   input logic                     clk,
   input logic                     rst_n,
   circuit_equiv_sequencer_if.slave bus
);

   localparam logic       JOHNSON     = (SEQ_MODE == 1);
   localparam logic [2:0] LAST_IDX    = lastIndex(JOHNSON);
   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

   seqState_e        state_q, state_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       settleCnt_q, settleCnt_d;
   logic [VEC_W-1:0] vec_q, vec_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [ERR_W-1:0] errCount_q, errCount_d;
   logic             failValid_q, failValid_d;
   logic [VEC_W-1:0] failVec_q, failVec_d;
   logic [3*Y_W-1:0] failY_q, failY_d;
   logic             mismatch;

   equiv_compare uCompare (
      .ySw_i      (bus.y_sw),
      .yAs_i      (bus.y_as),
      .yGt_i      (bus.y_gt),
      .mismatch_o (mismatch)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         settleCnt_q <= '0;
         vec_q       <= '0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         errCount_q  <= '0;
         failValid_q <= 1'b0;
         failVec_q   <= '0;
         failY_q     <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         settleCnt_q <= settleCnt_d;
         vec_q       <= vec_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         errCount_q  <= errCount_d;
         failValid_q <= failValid_d;
         failVec_q   <= failVec_d;
         failY_q     <= failY_d;
      end
   end

   // Abort overrides everything, including a simultaneous start.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      settleCnt_d = settleCnt_q;
      vec_d       = vec_q;
      done_d      = 1'b0;
      pass_d      = pass_q;
      errCount_d  = errCount_q;
      failValid_d = failValid_q;
      failVec_d   = failVec_q;
      failY_d     = failY_q;

      if (bus.abort) begin
         state_d = IDLE;
         vec_d   = '0;
         pass_d  = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               vec_d = '0;
               if (bus.start) begin
                  state_d     = DRIVE;
                  idx_d       = '0;
                  errCount_d  = '0;
                  failValid_d = 1'b0;
                  failVec_d   = '0;
                  failY_d     = '0;
                  pass_d      = 1'b0;
               end
            end
            DRIVE: begin
               vec_d       = vecAt(JOHNSON, idx_q);
               settleCnt_d = SETTLE_LOAD;
               state_d     = SETTLE;
            end
            SETTLE: begin
               if (settleCnt_q == 8'd0) state_d = SAMPLE;
               else                     settleCnt_d = settleCnt_q - 8'd1;
            end
            SAMPLE: begin
               if (mismatch) begin
                  if (errCount_q != '1) errCount_d = errCount_q + 4'd1;
                  if (!failValid_q) begin
                     failValid_d = 1'b1;
                     failVec_d   = vec_q;
                     failY_d     = {bus.y_sw, bus.y_as, bus.y_gt};
                  end
               end
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = DRIVE;
               end
            end
            DONE: begin
               done_d  = 1'b1;
               pass_d  = (errCount_q == '0);
               vec_d   = '0;
               idx_d   = '0;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign bus.a          = vec_q[2];
   assign bus.b          = vec_q[1];
   assign bus.c          = vec_q[0];
   assign bus.busy       = (state_q != IDLE);
   assign bus.done       = done_q;
   assign bus.pass       = pass_q;
   assign bus.err_count  = errCount_q;
   assign bus.fail_valid = failValid_q;
   assign bus.fail_vec   = failVec_q;
   assign bus.fail_y     = failY_q;

endmodule

// File: tb/tb_circuit_equiv_sequencer.sv
// Bench for circuit_equiv_sequencer: three DUTs (binary S=4, Johnson S=4, binary S=1) driven by
// randomized fault masks, aborts and stray starts, checked cycle by cycle against a sweep-level model.
module tb_circuit_equiv_sequencer;

   logic            clk;
   logic            rst_n;
   logic [2:0]      startReq;
   logic [2:0]      abortReq;
   logic [2:0][7:0] swMask;
   logic [2:0][7:0] gtMask;

   logic [2:0][2:0] obsVec;
   logic [2:0]      obsBusy;
   logic [2:0]      obsDone;
   logic [2:0]      obsPass;
   logic [2:0][3:0] obsErr;
   logic [2:0]      obsFailValid;
   logic [2:0][2:0] obsFailVec;
   logic [2:0][5:0] obsFailY;

   int numChecks      = 0;
   int numMiscompares = 0;

   // Reference circuit: y1 = a & b, y0 = b | c, with a as the MSB of the vector.
   function automatic logic [1:0] circuitFn(input logic [2:0] v);
      return {v[2] & v[1], v[1] | v[0]};
   endfunction

   for (genvar g = 0; g < 3; g++) begin : gDut
      circuit_equiv_sequencer_if bus ();
      logic [2:0] v;

      assign v         = {bus.a, bus.b, bus.c};
      assign bus.start = startReq[g];
      assign bus.abort = abortReq[g];
      assign bus.y_as  = circuitFn(v);
      assign bus.y_sw  = circuitFn(v) ^ {swMask[g][v], 1'b0};
      assign bus.y_gt  = circuitFn(v) ^ {1'b0, gtMask[g][v]};

      assign obsVec[g]       = v;
      assign obsBusy[g]      = bus.busy;
      assign obsDone[g]      = bus.done;
      assign obsPass[g]      = bus.pass;
      assign obsErr[g]       = bus.err_count;
      assign obsFailValid[g] = bus.fail_valid;
      assign obsFailVec[g]   = bus.fail_vec;
      assign obsFailY[g]     = bus.fail_y;

      circuit_equiv_sequencer #(
         .SETTLE_CYCLES (g == 2 ? 1 : 4),
         .SEQ_MODE      (g == 1 ? 1 : 0)
      ) dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus)
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int modeOf(input int m);
      return (m == 1) ? 1 : 0;
   endfunction

   function automatic int settleOf(input int m);
      return (m == 2) ? 1 : 4;
   endfunction

   function automatic int numVec(input int m);
      return (modeOf(m) == 1) ? 6 : 8;
   endfunction

   function automatic logic [2:0] vecOf(input int m, input int i);
      logic [2:0] walk [6];
      walk = '{3'b000, 3'b100, 3'b110, 3'b111, 3'b011, 3'b001};
      if (modeOf(m) == 1) return walk[i];
      return 3'(i);
   endfunction

   // Outcome of all vectors whose sample edge lies within upTo edges of the start edge.
   function automatic void modelSamples(input int m, input int upTo, output int errs,
                                        output logic fv, output logic [2:0] fvec,
                                        output logic [5:0] fy);
      int p;
      logic [2:0] v;
      logic [1:0] f;
      p    = settleOf(m) + 2;
      errs = 0;
      fv   = 1'b0;
      fvec = 3'b000;
      fy   = 6'b000000;
      for (int i = 0; i < numVec(m); i++) begin
         v = vecOf(m, i);
         if ((i + 1) * p <= upTo && (swMask[m][v] || gtMask[m][v])) begin
            if (errs < 15) errs++;
            if (!fv) begin
               fv   = 1'b1;
               fvec = v;
               f    = circuitFn(v);
               fy   = {f ^ {swMask[m][v], 1'b0}, f, f ^ {1'b0, gtMask[m][v]}};
            end
         end
      end
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      numChecks++;
      if (observed !== expected) begin
         numMiscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, observed, expected, $time);
      end
   endtask

   task automatic checkDut(input int m, input logic [2:0] eVec, input logic eBusy,
                           input logic eDone, input logic ePass, input int eErr,
                           input logic eFv, input logic [2:0] eFvec, input logic [5:0] eFy);
      checkOutput($sformatf("d%0d abc", m),        32'(obsVec[m]),       32'(eVec));
      checkOutput($sformatf("d%0d busy", m),       32'(obsBusy[m]),      32'(eBusy));
      checkOutput($sformatf("d%0d done", m),       32'(obsDone[m]),      32'(eDone));
      checkOutput($sformatf("d%0d pass", m),       32'(obsPass[m]),      32'(ePass));
      checkOutput($sformatf("d%0d err_count", m),  32'(obsErr[m]),       eErr);
      checkOutput($sformatf("d%0d fail_valid", m), 32'(obsFailValid[m]), 32'(eFv));
      checkOutput($sformatf("d%0d fail_vec", m),   32'(obsFailVec[m]),   32'(eFvec));
      checkOutput($sformatf("d%0d fail_y", m),     32'(obsFailY[m]),     32'(eFy));
   endtask

   // One sweep on DUT m; j counts rising edges since the edge that sampled start.
   task automatic applyStimulus(input int m, input int abortAt, input int restartAt);
      int p, len, lastJ, upTo, errs;
      logic fv;
      logic [2:0] fvec, eVec;
      logic [5:0] fy;
      logic eBusy, eDone, ePass;
      p     = settleOf(m) + 2;
      len   = numVec(m) * p + 1;
      lastJ = (abortAt >= 0) ? abortAt + 1 : len;
      ePass = 1'b0;
      errs  = 0;
      fv    = 1'b0;
      fvec  = 3'b000;
      fy    = 6'b000000;
      @(negedge clk);
      startReq[m] = 1'b1;
      @(negedge clk);
      startReq[m] = 1'b0;
      for (int j = 0; j <= lastJ; j++) begin
         upTo = (abortAt >= 0 && j == lastJ) ? j - 1 : j;
         modelSamples(m, upTo, errs, fv, fvec, fy);
         eBusy = (j < lastJ);
         eDone = (abortAt < 0 && j == len);
         ePass = eDone && (errs == 0);
         eVec  = (j >= 1 && j < lastJ) ? vecOf(m, (j - 1) / p) : 3'b000;
         checkDut(m, eVec, eBusy, eDone, ePass, errs, fv, fvec, fy);
         abortReq[m] = (j == abortAt);
         startReq[m] = (j == restartAt);
         @(negedge clk);
      end
      for (int k = 0; k < 2; k++) begin
         checkDut(m, 3'b000, 1'b0, 1'b0, ePass, errs, fv, fvec, fy);
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: time limit reached before the summary");
      $fatal(1, "[TB] simulation did not complete");
   end

   initial begin
      rst_n    = 1'b0;
      startReq = '0;
      abortReq = '0;
      swMask   = '0;
      gtMask   = '0;
      repeat (3) @(negedge clk);
      for (int m = 0; m < 3; m++) checkDut(m, 3'b000, 1'b0, 1'b0, 1'b0, 0, 1'b0, 3'b000, 6'b000000);
      rst_n = 1'b1;

      // Clean sweeps in each configuration.
      applyStimulus(0, -1, -1);
      applyStimulus(1, -1, -1);
      applyStimulus(2, -1, -1);

      // gate-level y0 wrong on 101
      gtMask[0] = 8'b0010_0000;
      applyStimulus(0, -1, -1);

      // switch-level wrong on 011 and 110
      gtMask[0] = 8'h00;
      swMask[0] = 8'b0100_1000;
      applyStimulus(0, -1, -1);

      // abort during SETTLE of vector 3, then a clean sweep
      swMask[0] = 8'h00;
      applyStimulus(0, 3 * 6 + 2, -1);
      applyStimulus(0, -1, -1);

      for (int r = 0; r < 14; r++) begin
         int m, len, ab, rs;
         m         = $urandom_range(0, 2);
         swMask[m] = 8'($urandom) & 8'($urandom);
         gtMask[m] = 8'($urandom) & 8'($urandom);
         len       = numVec(m) * (settleOf(m) + 2) + 1;
         ab        = -1;
         rs        = -1;
         if ($urandom_range(0, 3) == 0) ab = $urandom_range(0, len - 1);
         if ($urandom_range(0, 1) == 1) rs = $urandom_range(0, (ab >= 0) ? ab : len - 1);
         applyStimulus(m, ab, rs);
      end

      // Asynchronous reset pulse mid-sweep, between clock edges.
      swMask    = '0;
      gtMask    = '0;
      gtMask[0] = 8'h01;
      @(negedge clk);
      startReq[0] = 1'b1;
      @(negedge clk);
      startReq[0] = 1'b0;
      repeat (20) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      for (int m = 0; m < 3; m++) checkDut(m, 3'b000, 1'b0, 1'b0, 1'b0, 0, 1'b0, 3'b000, 6'b000000);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      checkDut(0, 3'b000, 1'b0, 1'b0, 1'b0, 0, 1'b0, 3'b000, 6'b000000);

      gtMask[0] = 8'h00;
      applyStimulus(0, -1, 10);

      $display("== %0d vectors applied, %0d miscompares ==", numChecks, numMiscompares);
      $finish;
   end

endmodule
